// File: rtl/uc_pkg.sv
// Shared microcontroller definitions: condition codes, flag bit positions, PC-stage FSM states.
package uc_pkg;

    localparam logic [2:0] CC_ALWAYS = 3'b000;
    localparam logic [2:0] CC_Z      = 3'b001;
    localparam logic [2:0] CC_NZ     = 3'b010;
    localparam logic [2:0] CC_C      = 3'b011;
    localparam logic [2:0] CC_NC     = 3'b100;
    localparam logic [2:0] CC_N      = 3'b101;
    localparam logic [2:0] CC_V      = 3'b110;
    localparam logic [2:0] CC_LT     = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

    // Shortest REDIR dwell; covers the hold counter's half-cycle reaction to jmp_taken.
    localparam int REDIR_MIN = 2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } pc_state_t;

endpackage

// File: rtl/uc_pc_ctrl_if.sv
// PC-stage bus: decode/flag/hold inputs towards the PC controller, fetch address and redirect pulse back.
interface uc_pc_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              stall_in;
    logic              instr_valid;
    logic              is_jmp;
    logic              is_cjmp;
    logic [2:0]        cond;
    logic [ADDR_W-1:0] jmp_target;
    logic              flags_we;
    logic [3:0]        flags_in;
    logic              condjmp_hold;

    logic [ADDR_W-1:0] pc;
    logic              fetch_en;
    logic              jmp_taken;
    logic [3:0]        flags;

    modport master (
        output stall_in, instr_valid, is_jmp, is_cjmp, cond, jmp_target,
               flags_we, flags_in, condjmp_hold,
        input  pc, fetch_en, jmp_taken, flags
    );

    modport slave (
        input  stall_in, instr_valid, is_jmp, is_cjmp, cond, jmp_target,
               flags_we, flags_in, condjmp_hold,
        output pc, fetch_en, jmp_taken, flags
    );
endinterface

// File: rtl/uc_cond_eval.sv
// Jump/conditional-move condition evaluator: purely combinational, no backpressure.
module uc_cond_eval
    import uc_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] flags,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_ALWAYS: cond_true = 1'b1;
            CC_Z:      cond_true = flags[FLG_Z];
            CC_NZ:     cond_true = !flags[FLG_Z];
            CC_C:      cond_true = flags[FLG_C];
            CC_NC:     cond_true = !flags[FLG_C];
            CC_N:      cond_true = flags[FLG_N];
            CC_V:      cond_true = flags[FLG_V];
            CC_LT:     cond_true = flags[FLG_N] ^ flags[FLG_V];
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/uc_pc_ctrl.sv
// PC register, branch resolution and fetch gating; pc/jmp_taken/flags registered, fetch_en combinational.
// Freezes on stall_in or condjmp_hold; a taken jump costs at least REDIR_MIN fetch-free cycles.
module uc_pc_ctrl
    import uc_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input logic         clk,
    input logic         reset,
    uc_pc_ctrl_if.slave bus
);

    localparam logic [1:0] DWELL_LAST = 2'(REDIR_MIN - 1);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        flags_q, flags_d;
    logic              jmp_taken_q, jmp_taken_d;
    logic [1:0]        dwell_q, dwell_d;
    logic              fetch_en;

    logic [3:0]        eff_flags;
    logic              cond_true;
    logic              take;
    logic              frozen;

    // A flag write in the same cycle as a conditional jump must steer that jump.
    assign eff_flags = bus.flags_we ? bus.flags_in : flags_q;

    uc_cond_eval u_cond_eval (
        .cond      (bus.cond),
        .flags     (eff_flags),
        .cond_true (cond_true)
    );

    assign take   = bus.instr_valid & (bus.is_jmp | (bus.is_cjmp & cond_true));
    assign frozen = bus.stall_in | bus.condjmp_hold;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        dwell_d     = dwell_q;
        jmp_taken_d = 1'b0;
        fetch_en    = 1'b0;
        flags_d     = bus.flags_we ? bus.flags_in : flags_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                // A foreign hold pulse in RUN behaves like REDIR: nothing moves.
                fetch_en = !frozen;
                if (!frozen) begin
                    if (take) begin
                        pc_d        = bus.jmp_target;
                        jmp_taken_d = 1'b1;
                        dwell_d     = '0;
                        state_d     = REDIR;
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            REDIR: begin
                if (dwell_q < DWELL_LAST) begin
                    dwell_d = dwell_q + 2'd1;
                end else if (!bus.condjmp_hold) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VEC;
            flags_q     <= '0;
            jmp_taken_q <= 1'b0;
            dwell_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            flags_q     <= flags_d;
            jmp_taken_q <= jmp_taken_d;
            dwell_q     <= dwell_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.fetch_en  = fetch_en;
    assign bus.jmp_taken = jmp_taken_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_uc_pc_ctrl.sv
module tb_uc_pc_ctrl;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uc_pc_ctrl_if #(.ADDR_W(AW)) bus ();
    uc_pc_ctrl_if #(.ADDR_W(4))  bus4 ();

    uc_pc_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
    uc_pc_ctrl #(.ADDR_W(4), .RESET_VEC(4'd14)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    int n_tests, n_fail;

    // Reference: mode 0 = boot bubble, 1 = running, 2 = redirect bubble (age = cycles spent there)
    int m_pc, m_flags, m_jt, m_mode, m_age;
    int m4_pc, m4_mode;
    // Environment model of the downstream hold counter
    int hold_len, hold_left;
    bit ext_hold;

    function automatic bit ref_cond(int cc, int f);
        bit z, n, c, v;
        bit tbl [8];
        z = f[0]; n = f[1]; c = f[2]; v = f[3];
        tbl = '{1'b1, z, !z, c, !c, n, v, n != v};
        return tbl[cc & 7];
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int eff;
        bit hold;
        hold = bus.condjmp_hold;
        if (reset) begin
            m_pc = 0; m_flags = 0; m_jt = 0; m_mode = 0; m_age = 0;
            m4_pc = 14; m4_mode = 0;
            return;
        end
        eff = bus.flags_we ? int'(bus.flags_in) : m_flags;
        if (bus.flags_we) m_flags = bus.flags_in;
        m_jt = 0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!bus.stall_in && !hold) begin
                if (bus.instr_valid && (bus.is_jmp || (bus.is_cjmp && ref_cond(bus.cond, eff)))) begin
                    m_pc = bus.jmp_target; m_jt = 1; m_mode = 2; m_age = 1;
                end else begin
                    m_pc = (m_pc + 1) % (1 << AW);
                end
            end
        end else begin
            if (m_age >= 2 && !hold) m_mode = 1;
            else m_age++;
        end
        if (m4_mode == 0) m4_mode = 1;
        else m4_pc = (m4_pc + 1) % 16;
    endtask

    // Called at a falling edge with this cycle's inputs applied; ends at the next falling edge.
    task automatic tick();
        bus.condjmp_hold = (hold_left > 0) || ext_hold;
        #1;
        chk("pc", bus.pc, m_pc);
        chk("fetch_en", bus.fetch_en, (m_mode == 1 && !bus.stall_in && !bus.condjmp_hold));
        chk("jmp_taken", bus.jmp_taken, m_jt);
        chk("flags", bus.flags, m_flags);
        chk("pc_w4", bus4.pc, m4_pc);
        chk("fetch_en_w4", bus4.fetch_en, m4_mode == 1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_jt != 0) hold_left = hold_len;
        else if (hold_left > 0) hold_left--;
    endtask

    initial begin
        int found;
        n_tests = 0; n_fail = 0;
        hold_len = 0; hold_left = 0; ext_hold = 0;
        reset = 1'b1;
        bus.stall_in = 0; bus.instr_valid = 0; bus.is_jmp = 0; bus.is_cjmp = 0;
        bus.cond = 0; bus.jmp_target = 0; bus.flags_we = 0; bus.flags_in = 0;
        bus.condjmp_hold = 0;
        bus4.stall_in = 0; bus4.instr_valid = 0; bus4.is_jmp = 0; bus4.is_cjmp = 0;
        bus4.cond = 0; bus4.jmp_target = 0; bus4.flags_we = 0; bus4.flags_in = 0;
        bus4.condjmp_hold = 0;
        repeat (2) @(posedge clk);
        model_edge();
        @(negedge clk);
        tick();

        // Free run after reset release; narrow instance wraps 14,15,0,1
        reset = 1'b0; bus.instr_valid = 1;
        repeat (6) tick();

        // Unconditional jump with a two-cycle hold
        hold_len = 2;
        bus.is_jmp = 1; bus.jmp_target = 10'h155;
        tick();
        bus.is_jmp = 0;
        repeat (6) tick();

        // Every condition code, both outcomes, via bypass and via the register
        hold_len = 0;
        for (int c = 0; c < 8; c++) begin
            for (int w = 0; w < 2; w++) begin
                found = -1;
                for (int f = 0; f < 16; f++)
                    if (found < 0 && ref_cond(c, f) == w[0]) found = f;
                if (found >= 0) begin
                    bus.jmp_target = 10'(12 * c + w + 40);
                    bus.flags_we = 1; bus.flags_in = ~4'(found); bus.is_cjmp = 0;
                    tick();
                    bus.flags_in = 4'(found); bus.cond = 3'(c); bus.is_cjmp = 1;
                    tick();
                    bus.is_cjmp = 0; bus.flags_we = 0;
                    repeat (4) tick();
                    bus.flags_we = 1; bus.flags_in = 4'(found);
                    tick();
                    bus.flags_we = 0; bus.flags_in = ~4'(found); bus.is_cjmp = 1;
                    tick();
                    bus.is_cjmp = 0;
                    repeat (4) tick();
                end
            end
        end

        // Taken jump held off by a 3-cycle stall
        hold_len = 1;
        bus.is_jmp = 1; bus.jmp_target = 10'h2A0; bus.stall_in = 1;
        repeat (3) tick();
        bus.stall_in = 0;
        tick();
        bus.is_jmp = 0;
        repeat (5) tick();

        // Hold not caused by this block freezes RUN
        ext_hold = 1; bus.is_jmp = 1; bus.jmp_target = 10'h0AA;
        repeat (2) tick();
        ext_hold = 0;
        tick();
        bus.is_jmp = 0;
        repeat (5) tick();

        // Self-loop, then jump near the top of the address space to see the wrap
        bus.is_jmp = 1; bus.jmp_target = AW'(m_pc);
        tick();
        bus.is_jmp = 0;
        repeat (4) tick();
        bus.is_jmp = 1; bus.jmp_target = 10'h3FE;
        tick();
        bus.is_jmp = 0;
        repeat (6) tick();

        // Reset in the middle of a redirect
        hold_len = 3;
        bus.is_jmp = 1; bus.jmp_target = 10'h100; bus.flags_we = 1; bus.flags_in = 4'hF;
        tick();
        bus.is_jmp = 0; bus.flags_we = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        repeat (2) tick();
        bus.is_jmp = 1; bus.jmp_target = 10'h055;
        tick();
        bus.is_jmp = 0;
        repeat (6) tick();

        // Random traffic
        repeat (400) begin
            reset            = ($urandom_range(0, 99) == 0);
            bus.stall_in     = ($urandom_range(0, 3) == 0);
            bus.instr_valid  = ($urandom_range(0, 4) != 0);
            bus.is_jmp       = ($urandom_range(0, 9) == 0);
            bus.is_cjmp      = ($urandom_range(0, 2) == 0);
            bus.cond         = 3'($urandom_range(0, 7));
            bus.jmp_target   = AW'($urandom);
            bus.flags_we     = ($urandom_range(0, 2) == 0);
            bus.flags_in     = 4'($urandom_range(0, 15));
            ext_hold         = ($urandom_range(0, 19) == 0);
            hold_len         = $urandom_range(0, 3);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
